ram_port_arbiter: RTL

//  Shares the single byte-wide RAM port between a burst reader (operand/opcode loader) and a burst writer (store/push).

---
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Reader, writer and RAM-side signals of ram_port_arbiter, bundled as one port.
// master = the arbiter itself, slave = the requesters/RAM around it.
interface ram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int LW = 3
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] rd_len;
    logic          rd_gnt;
    logic          rd_vld;
    logic [LW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          rd_done;

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_len;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          wr_ack;
    logic          wr_done;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    modport master (
        input  rd_req, rd_addr, rd_len,
        input  wr_req, wr_addr, wr_len, wr_data,
        input  ram_q,
        output rd_gnt, rd_vld, rd_idx, rd_data, rd_done,
        output wr_gnt, wr_ack, wr_done,
        output ram_addr, ram_we, ram_d
    );

    modport slave (
        output rd_req, rd_addr, rd_len,
        output wr_req, wr_addr, wr_len, wr_data,
        output ram_q,
        input  rd_gnt, rd_vld, rd_idx, rd_data, rd_done,
        input  wr_gnt, wr_ack, wr_done,
        input  ram_addr, ram_we, ram_d
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide RAM port between a burst reader and a burst writer.
// MEMARB_RR_EN defined: round-robin tie-break; undefined: writer wins ties.
module ram_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int LW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RBURST = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] hold_q, hold_d;

    logic [AW-1:0] burst_addr;
    logic          last_byte;
    logic          owner_req;
    logic          grant_rd;
    logic          grant_wr;

    // Address arithmetic wraps naturally at AW bits.
    assign burst_addr = base_q + {{(AW-LW){1'b0}}, cnt_q};
    assign last_byte  = (cnt_q == len_q);

`ifdef MEMARB_RR_EN
    logic last_wr_q, last_wr_d;

    // On a tie the requester that was not served last wins.
    assign grant_rd = bus.rd_req & (~bus.wr_req | last_wr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b1;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        last_wr_d = last_wr_q;
        if (state_q == ST_IDLE) begin
            if (grant_rd) begin
                last_wr_d = 1'b0;
            end else if (grant_wr) begin
                last_wr_d = 1'b1;
            end
        end
    end
`else
    assign grant_rd = bus.rd_req & ~bus.wr_req;
`endif

    assign grant_wr = bus.wr_req & ~grant_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        hold_d       = hold_q;
        owner_req    = 1'b0;

        bus.rd_gnt   = 1'b0;
        bus.rd_vld   = 1'b0;
        bus.rd_idx   = '0;
        bus.rd_data  = '0;
        bus.rd_done  = 1'b0;
        bus.wr_gnt   = 1'b0;
        bus.wr_ack   = 1'b0;
        bus.wr_done  = 1'b0;
        bus.ram_addr = hold_q;
        bus.ram_we   = 1'b0;
        bus.ram_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    state_d = ST_RBURST;
                    base_d  = bus.rd_addr;
                    len_d   = bus.rd_len;
                    cnt_d   = '0;
                end else if (grant_wr) begin
                    state_d = ST_WBURST;
                    base_d  = bus.wr_addr;
                    len_d   = bus.wr_len;
                    cnt_d   = '0;
                end
            end

            ST_RBURST, ST_WBURST: begin
                owner_req    = (state_q == ST_RBURST) ? bus.rd_req : bus.wr_req;
                bus.ram_addr = burst_addr;
                hold_d       = burst_addr;
                if (state_q == ST_RBURST) begin
                    bus.rd_gnt  = 1'b1;
                    bus.rd_vld  = 1'b1;
                    bus.rd_idx  = cnt_q;
                    bus.rd_data = bus.ram_q;
                    bus.rd_done = last_byte;
                end else begin
                    bus.wr_gnt  = 1'b1;
                    bus.wr_ack  = 1'b1;
                    bus.wr_done = last_byte;
                    bus.ram_we  = 1'b1;
                    bus.ram_d   = bus.wr_data;
                end
                // A dropped request ends the burst after the current byte, without done.
                if (last_byte || !owner_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
